// File: rtl/pc_gen_if.sv
// Fetch-PC generator bus: ready/stall controls, redirect requests, BTB updates, PC out.
// Latency: n/a (signal bundle only).
// Backpressure: rdy low freezes PC movement in the generator; no handshake of its own.
interface pc_gen_if #(
    parameter int ADDR_W    = 32,
    parameter int NUM_REDIR = 2,
    parameter int STALL_W   = 6
);
    logic                          rdy;
    logic [STALL_W-1:0]            stall;
    logic [NUM_REDIR-1:0]          redir_valid;
    logic [NUM_REDIR*ADDR_W-1:0]   redir_addr;
    logic                          btb_upd_valid;
    logic [ADDR_W-1:0]             btb_upd_pc;
    logic [ADDR_W-1:0]             btb_upd_target;
    logic                          btb_upd_taken;
    logic [ADDR_W-1:0]             pc;
    logic                          redir_pending;
    logic                          pred_taken;

    // Requester side: drives controls/redirects/updates, observes the fetch PC.
    modport master (
        output rdy, stall, redir_valid, redir_addr,
        output btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
        input  pc, redir_pending, pred_taken
    );

    // Generator side.
    modport slave (
        input  rdy, stall, redir_valid, redir_addr,
        input  btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
        output pc, redir_pending, pred_taken
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-PC generator: sequential advance, prioritised redirects, parked redirect, optional BTB (PC_GEN_BTB_EN).
// Latency: redirect/advance visible on pc one cycle after the edge; parked redirect one cycle after rdy returns.
// Backpressure: rdy low freezes pc (redirects are parked); stall[0] holds only the sequential path.
module pc_gen #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                STEP      = 4,
    parameter int                NUM_REDIR = 2,
    parameter int                STALL_W   = 6,
    parameter int                BTB_DEPTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);
    localparam int                SHIFT      = $clog2(STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << SHIFT;
    localparam logic [ADDR_W-1:0] STEP_V     = ADDR_W'(STEP);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] park_q;
    logic              pend_q;
    logic [ADDR_W-1:0] sel_addr;
    logic              any_redir;
    logic              pred_hit;
    logic [ADDR_W-1:0] pred_target;
    logic [ADDR_W-1:0] seq_next;

    assign any_redir = |bus.redir_valid;

    // Pick the lowest-index active redirect source (index 0 wins).
    always_comb begin
        sel_addr = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (bus.redir_valid[i]) begin
                sel_addr = bus.redir_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

`ifdef PC_GEN_BTB_EN
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - SHIFT - IDX_W;

    logic [BTB_DEPTH-1:0] btb_vld;
    logic [TAG_W-1:0]     btb_tag [BTB_DEPTH];
    logic [ADDR_W-1:0]    btb_tgt [BTB_DEPTH];
    logic [IDX_W-1:0]     look_idx;
    logic [TAG_W-1:0]     look_tag;
    logic [IDX_W-1:0]     upd_idx;
    logic [TAG_W-1:0]     upd_tag;
    logic                 unused_upd;

    assign look_idx    = pc_q[SHIFT +: IDX_W];
    assign look_tag    = pc_q[ADDR_W-1 -: TAG_W];
    assign upd_idx     = bus.btb_upd_pc[SHIFT +: IDX_W];
    assign upd_tag     = bus.btb_upd_pc[ADDR_W-1 -: TAG_W];
    assign pred_hit    = btb_vld[look_idx] && (btb_tag[look_idx] == look_tag);
    assign pred_target = btb_tgt[look_idx];
    assign unused_upd  = ^{bus.stall, bus.btb_upd_pc};

    // Valid bits: cleared by reset, set by taken updates, dropped by matching not-taken updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            btb_vld <= '0;
        end else if (bus.btb_upd_valid) begin
            if (bus.btb_upd_taken) begin
                btb_vld[upd_idx] <= 1'b1;
            end else if (btb_tag[upd_idx] == upd_tag) begin
                btb_vld[upd_idx] <= 1'b0;
            end
        end
    end

    // Tag/target payload; meaningless while the valid bit is clear, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && bus.btb_upd_valid && bus.btb_upd_taken) begin
            btb_tag[upd_idx] <= upd_tag;
            btb_tgt[upd_idx] <= bus.btb_upd_target & ALIGN_MASK;
        end
    end
`else
    logic unused_upd;

    assign pred_hit    = 1'b0;
    assign pred_target = '0;
    assign unused_upd  = ^{bus.stall, bus.btb_upd_valid, bus.btb_upd_pc,
                           bus.btb_upd_target, bus.btb_upd_taken};
`endif

    assign seq_next = pred_hit ? pred_target : pc_q + STEP_V;

    // PC and parked-redirect state, first matching case wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_VEC;
            park_q <= '0;
            pend_q <= 1'b0;
        end else if (any_redir && bus.rdy) begin
            pc_q   <= sel_addr & ALIGN_MASK;
            pend_q <= 1'b0;
        end else if (any_redir) begin
            park_q <= sel_addr & ALIGN_MASK;
            pend_q <= 1'b1;
        end else if (pend_q && bus.rdy) begin
            pc_q   <= park_q;
            pend_q <= 1'b0;
        end else if (bus.rdy && !bus.stall[0]) begin
            pc_q   <= seq_next;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.redir_pending = pend_q;
    assign bus.pred_taken    = pred_hit;
endmodule
